fround_pipe: RTL and testbench
==============================

FROUND_PIPE -- requirements
Module: fround_pipe

Interface
REQ-001 SHALL have parameter NSTAGE, default 2, meaning pipeline depth in cycles from input accept to output valid (legal 1..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port x  input  32  IEEE-754 binary32 operand.
REQ-005 SHALL have port mode  input  2  rounding mode: 00 FLOOR, 01 CEIL, 10 TRUNC, 11 RNE (nearest-even).
REQ-006 SHALL have port in_valid  input  1  operand/mode valid.
REQ-007 SHALL have port in_ready  output  1  block accepts operand this cycle.
REQ-008 SHALL have port y  output  32  binary32 integral-valued result.
REQ-009 SHALL have port out_valid  output  1  y valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts y this cycle.

Function
REQ-011 SHALL accept a transaction when in_valid && in_ready; mode SHALL be captured with x and travel with it.
REQ-012 SHALL define advance = !out_valid || out_ready; all NSTAGE stages shift together only on advance; in_ready SHALL equal advance (combinational).
REQ-013 SHALL, without backpressure, assert out_valid exactly NSTAGE cycles after the accepting edge, one result per cycle at full throughput.
REQ-014 SHALL hold y and out_valid stable while out_valid && !out_ready; no transaction lost or duplicated.
REQ-015 SHALL accept a new operand in the same cycle the output is consumed (out_valid && out_ready).
REQ-016 SHALL deliver results in acceptance order; bubbles (in_valid low on an advance) propagate as invalid stages.
REQ-017 SHALL, for |x| >= 2^23 (biased exp >= 150) or x = +/-inf, return x unchanged.
REQ-018 SHALL return quiet NaN 0x7FC00000 for any NaN input.
REQ-019 SHALL treat subnormal inputs as signed zero (flush-to-zero) and return that signed zero in all modes.
REQ-020 SHALL, for 0 < |x| < 1: FLOOR gives +0 (x>0) or -1.0 (x<0); CEIL gives +1.0 (x>0) or -0 (x<0); TRUNC gives signed zero; RNE gives signed zero for |x| <= 0.5, signed 1.0 otherwise.
REQ-021 SHALL, for 1 <= |x| < 2^23, clear fraction bits below the binary point, then add one ulp-of-integer magnitude when: FLOOR and x<0 and any cleared bit set; CEIL and x>0 and any cleared bit set; RNE and (guard && (sticky || lsb)).
REQ-022 SHALL renormalise a magnitude carry-out (e.g. 1.5 -> 2.0) by incrementing exponent and zeroing mantissa.
REQ-023 SHALL preserve sign of x in y in all cases (e.g. FLOOR(-0.0) = -0.0, CEIL(-0.25) = -0.0).
REQ-024 SHALL produce results bit-exact to C floorf/ceilf/truncf/nearbyintf(RNE) for all normal, zero, inf inputs.

Reset
REQ-025 SHALL, while rst high at a rising edge, clear all stage valid bits; out_valid = 0, y = 32'h0, in_ready = 1 after that edge.
REQ-026 SHALL discard all in-flight transactions on reset mid-operation; no stale result emitted afterward.
REQ-027 SHALL not accept a transaction on an edge where rst is high.

Configuration
REQ-028 SHALL, when macro FROUND_FLAGS_EN is defined, add outputs inexact (1 bit, y != x for finite non-NaN x) and invalid (1 bit, x is signalling NaN), aligned with y/out_valid, reset to 0, held under stall.
REQ-029 SHALL, without FROUND_FLAGS_EN, have no flag ports and no flag logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: NSTAGE=2, out_ready=1, x=0xBFC00000 (-1.5) each mode -> FLOOR 0xC0000000, CEIL 0xBF800000, TRUNC 0xBF800000, RNE 0xC0000000, out_valid 2 cycles after accept.
REQ-031 SHALL cover: RNE ties 0x3F000000 (0.5) -> 0x00000000, 0x40200000 (2.5) -> 0x40000000, 0x40600000 (3.5) -> 0x40800000.
REQ-032 SHALL cover: back-to-back stream of 16 operands, out_ready low for 5 cycles mid-stream -> y frozen, in_ready low, all 16 results in order, none duplicated.
REQ-033 SHALL cover: specials 0x7F800000 -> 0x7F800000, 0x7FA00001 -> 0x7FC00000, 0x80000001 -> 0x80000000, 0x4B000001 -> 0x4B000001; with FROUND_FLAGS_EN, invalid=1 for 0x7FA00001.
REQ-034 SHALL cover: rst asserted one cycle with 3 transactions in flight -> out_valid 0 next cycle, no old result appears afterward, next accepted operand emerges NSTAGE cycles later.
REQ-035 SHALL cover: exhaustive sweep of all 2^32 inputs per mode against floorf/ceilf/truncf/nearbyintf, zero mismatches.

Source files
------------

// File: rtl/fround_pipe.sv
// Pipelined binary32 round-to-integral (FLOOR/CEIL/TRUNC/RNE) with valid/ready handshake.
// Optional exception flags (inexact, invalid) are enabled by defining FROUND_FLAGS_EN.
module fround_pipe #(
  parameter int unsigned NSTAGE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
`ifdef FROUND_FLAGS_EN
  ,
  output logic        inexact,
  output logic        invalid
`endif
);

  typedef enum logic [1:0] {
    ModeFloor = 2'b00,
    ModeCeil  = 2'b01,
    ModeTrunc = 2'b10,
    ModeRne   = 2'b11
  } mode_e;

  mode_e       rmode;
  logic        sign;
  logic [7:0]  exp_in;
  logic [22:0] man;
  logic [4:0]  sh;
  logic [24:0] sig;
  logic [24:0] int_part;
  logic [24:0] low_mask;
  logic [24:0] half_mask;
  logic [24:0] rnd_int;
  logic [24:0] rnd_sig;
  logic        any_frac;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic        carry;
  logic [31:0] res;
  logic        advance;

  // Rounding is done combinationally on the incoming operand; the stages only delay it.
  always_comb begin
    rmode     = mode_e'(mode);
    sign      = x[31];
    exp_in    = x[30:23];
    man       = x[22:0];
    sig       = {2'b01, man};
    // Number of fraction bits below the binary point; meaningful for exponents 127..149.
    sh        = 5'(8'd150 - exp_in);
    int_part  = sig >> sh;
    low_mask  = (25'd1 << sh) - 25'd1;
    half_mask = low_mask >> 1;
    any_frac  = |(sig & low_mask);
    guard     = |(sig & (low_mask ^ half_mask));
    sticky    = |(sig & half_mask);
    inc       = 1'b0;
    unique case (rmode)
      ModeFloor: inc = sign & any_frac;
      ModeCeil:  inc = ~sign & any_frac;
      ModeTrunc: inc = 1'b0;
      ModeRne:   inc = guard & (sticky | int_part[0]);
      default:   inc = 1'b0;
    endcase
    rnd_int = int_part + {24'd0, inc};
    rnd_sig = rnd_int << sh;
    // Result is either in [2^23, 2^24) or exactly 2^24 after a carry-out.
    carry   = rnd_sig[24] | ~rnd_sig[23];

    res = x;
    if (exp_in == 8'hFF) begin
      if (man != 23'd0) begin
        res = 32'h7FC0_0000;
      end
    end else if (exp_in == 8'd0) begin
      res = {sign, 31'd0};
    end else if (exp_in >= 8'd150) begin
      res = x;
    end else if (exp_in < 8'd127) begin
      res = {sign, 31'd0};
      unique case (rmode)
        ModeFloor: if (sign) res = 32'hBF80_0000;
        ModeCeil:  if (!sign) res = 32'h3F80_0000;
        ModeTrunc: res = {sign, 31'd0};
        ModeRne:   if (exp_in == 8'd126 && man != 23'd0) res = {sign, 8'd127, 23'd0};
        default:   res = {sign, 31'd0};
      endcase
    end else if (carry) begin
      res = {sign, exp_in + 8'd1, 23'd0};
    end else begin
      res = {sign, exp_in, rnd_sig[22:0]};
    end
  end

  logic [NSTAGE-1:0][31:0] y_q, y_d;
  logic [NSTAGE-1:0]       valid_q, valid_d;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign y         = y_q[NSTAGE-1];
  assign out_valid = valid_q[NSTAGE-1];

  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    if (advance) begin
      y_d[0]     = res;
      valid_d[0] = in_valid;
      for (int unsigned i = 1; i < NSTAGE; i++) begin
        y_d[i]     = y_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= '0;
      valid_q <= '0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

`ifdef FROUND_FLAGS_EN
  logic              res_inexact;
  logic              res_invalid;
  logic [NSTAGE-1:0] inx_q, inx_d;
  logic [NSTAGE-1:0] inv_q, inv_d;

  always_comb begin
    res_inexact = 1'b0;
    res_invalid = 1'b0;
    if (exp_in == 8'hFF) begin
      // Signalling NaN has a non-zero payload with the quiet bit clear.
      res_invalid = (man != 23'd0) && !man[22];
    end else begin
      res_inexact = (res != x);
    end
  end

  always_comb begin
    inx_d = inx_q;
    inv_d = inv_q;
    if (advance) begin
      inx_d[0] = res_inexact;
      inv_d[0] = res_invalid;
      for (int unsigned i = 1; i < NSTAGE; i++) begin
        inx_d[i] = inx_q[i-1];
        inv_d[i] = inv_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inx_q <= '0;
      inv_q <= '0;
    end else begin
      inx_q <= inx_d;
      inv_q <= inv_d;
    end
  end

  assign inexact = inx_q[NSTAGE-1];
  assign invalid = inv_q[NSTAGE-1];
`endif

endmodule

// File: tb/tb_fround_pipe.sv
// Directed self-checking bench for fround_pipe (NSTAGE = 2); flag checks follow FROUND_FLAGS_EN.
module tb_fround_pipe;
  localparam int unsigned NSTAGE = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;
`ifdef FROUND_FLAGS_EN
  logic        inexact;
  logic        invalid;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fround_pipe #(.NSTAGE(NSTAGE)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef FROUND_FLAGS_EN
    ,
    .inexact   (inexact),
    .invalid   (invalid)
`endif
  );

  // Sends one operand into an empty pipe and waits (bounded) for its result.
  task automatic apply(input logic [31:0] xi, input logic [1:0] mi, output logic [31:0] yo,
                       output int lat, output logic inx, output logic inv);
    @(negedge clk);
    x = xi; mode = mi; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; x = '0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    yo = y;
`ifdef FROUND_FLAGS_EN
    inx = inexact;
    inv = invalid;
`else
    inx = 1'b0;
    inv = 1'b0;
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = '0; mode = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (y !== 32'h0) begin
      errors++; $display("FAIL reset_y: got %h expected 00000000", y);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_modes;
    logic [31:0] texp[4];
    logic [31:0] r;
    int          lat;
    logic        inx, inv;
    texp = '{32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000, 32'hC000_0000};
    for (int m = 0; m < 4; m++) begin
      apply(32'hBFC0_0000, 2'(m), r, lat, inx, inv);
      checks++;
      if (lat != NSTAGE) begin
        errors++; $display("FAIL modes_latency m=%0d: got %0d expected %0d", m, lat, NSTAGE);
      end
      checks++;
      if (r !== texp[m]) begin
        errors++; $display("FAIL modes_y m=%0d: got %h expected %h", m, r, texp[m]);
      end
`ifdef FROUND_FLAGS_EN
      checks++;
      if (inx !== 1'b1) begin
        errors++; $display("FAIL modes_inexact m=%0d: got %b expected 1", m, inx);
      end
`endif
    end
  endtask

  task automatic test_rne_ties;
    logic [31:0] tx[6];
    logic [31:0] texp[6];
    logic [31:0] r;
    int          lat;
    logic        inx, inv;
    tx   = '{32'h3F00_0000, 32'h4020_0000, 32'h4060_0000, 32'h3F40_0000, 32'h4AFF_FFFF,
             32'hBF00_0000};
    texp = '{32'h0000_0000, 32'h4000_0000, 32'h4080_0000, 32'h3F80_0000, 32'h4B00_0000,
             32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      apply(tx[i], 2'b11, r, lat, inx, inv);
      checks++;
      if (r !== texp[i]) begin
        errors++; $display("FAIL rne x=%h: got %h expected %h", tx[i], r, texp[i]);
      end
    end
  endtask

  task automatic test_specials;
    logic [31:0] tx[7];
    logic [1:0]  tm[7];
    logic [31:0] texp[7];
    logic        tinv[7];
    logic [31:0] r;
    int          lat;
    logic        inx, inv;
    tx   = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FA0_0001, 32'h7FC0_0000, 32'h8000_0001,
             32'h4B00_0001, 32'h0040_0000};
    tm   = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1};
    texp = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h7FC0_0000, 32'h8000_0000,
             32'h4B00_0001, 32'h0000_0000};
    tinv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      apply(tx[i], tm[i], r, lat, inx, inv);
      checks++;
      if (r !== texp[i]) begin
        errors++; $display("FAIL special x=%h: got %h expected %h", tx[i], r, texp[i]);
      end
`ifdef FROUND_FLAGS_EN
      checks++;
      if (inv !== tinv[i]) begin
        errors++; $display("FAIL special_invalid x=%h: got %b expected %b", tx[i], inv, tinv[i]);
      end
`endif
    end
  endtask

  task automatic test_edges;
    logic [31:0] tx[8];
    logic [1:0]  tm[8];
    logic [31:0] texp[8];
    logic        tinx[8];
    logic [31:0] r;
    int          lat;
    logic        inx, inv;
    tx   = '{32'h8000_0000, 32'hBE80_0000, 32'hBE80_0000, 32'h3E80_0000, 32'h3E80_0000,
             32'hC030_0000, 32'h3F80_0001, 32'hC030_0000};
    tm   = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd3};
    texp = '{32'h8000_0000, 32'h8000_0000, 32'hBF80_0000, 32'h3F80_0000, 32'h0000_0000,
             32'hC000_0000, 32'h4000_0000, 32'hC040_0000};
    tinx = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      apply(tx[i], tm[i], r, lat, inx, inv);
      checks++;
      if (r !== texp[i]) begin
        errors++; $display("FAIL edge x=%h m=%0d: got %h expected %h", tx[i], tm[i], r, texp[i]);
      end
`ifdef FROUND_FLAGS_EN
      checks++;
      if (inx !== tinx[i]) begin
        errors++; $display("FAIL edge_inexact x=%h: got %b expected %b", tx[i], inx, tinx[i]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] tin[16];
    logic [31:0] texp[16];
    logic [31:0] hold;
    int          ni;
    int          no;
    tin  = '{32'h3FA0_0000, 32'h4010_0000, 32'h4050_0000, 32'h4088_0000, 32'h40A8_0000,
             32'h40C8_0000, 32'h40E8_0000, 32'h4104_0000, 32'h4114_0000, 32'h4124_0000,
             32'h4134_0000, 32'h4144_0000, 32'h4154_0000, 32'h4164_0000, 32'h4174_0000,
             32'h4182_0000};
    texp = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000,
             32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000, 32'h4110_0000, 32'h4120_0000,
             32'h4130_0000, 32'h4140_0000, 32'h4150_0000, 32'h4160_0000, 32'h4170_0000,
             32'h4180_0000};
    ni = 0; no = 0; hold = '0;
    for (int c = 0; c < 60 && no < 16; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 11);
      mode      = 2'b00;
      in_valid  = (ni < 16);
      x         = '0;
      if (ni < 16) x = tin[ni];
      #1;
      if (c == 6) hold = y;
      if (c >= 6 && c < 11) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL b2b_stall_in_ready c=%0d: got %b expected 0", c, in_ready);
        end
      end
      if (c >= 7 && c < 11) begin
        checks++;
        if (out_valid !== 1'b1 || y !== hold) begin
          errors++;
          $display("FAIL b2b_frozen c=%0d: got v=%b y=%h expected v=1 y=%h", c, out_valid, y, hold);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (y !== texp[no]) begin
          errors++; $display("FAIL b2b_order idx=%0d: got %h expected %h", no, y, texp[no]);
        end
        no++;
      end
      if (in_valid && in_ready) ni++;
    end
    checks++;
    if (no != 16) begin
      errors++; $display("FAIL b2b_count: got %0d expected 16", no);
    end
    in_valid = 1'b0; out_ready = 1'b1; x = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL b2b_duplicate: got out_valid %b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_reset_midflight;
    logic [31:0] tin[4];
    logic [31:0] r;
    int          lat;
    logic        inx, inv;
    tin = '{32'h3FA0_0000, 32'h4010_0000, 32'h4050_0000, 32'h40A8_0000};
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mode = 2'b00; out_ready = 1'b1; in_valid = 1'b1; x = tin[c];
      rst = (c == 3);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; x = '0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'h0) begin
      errors++; $display("FAIL midreset_clear: got v=%b y=%h expected v=0 y=00000000", out_valid, y);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL midreset_stale: got out_valid %b y=%h expected 0", out_valid, y);
      end
    end
    apply(32'h4088_0000, 2'b00, r, lat, inx, inv);
    checks++;
    if (lat != NSTAGE) begin
      errors++; $display("FAIL midreset_latency: got %0d expected %0d", lat, NSTAGE);
    end
    checks++;
    if (r !== 32'h4080_0000) begin
      errors++; $display("FAIL midreset_y: got %h expected 40800000", r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_modes();
    test_rne_ties();
    test_specials();
    test_edges();
    test_back_to_back();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
